// File: rtl/psumgb_arb.sv
// psumgb_arb -- partial-sum gather arbiter between the PEB array and the
// global buffer (GB).
//
// Each PEB offers a stream of PSUM_WIDTH-bit beats. The arbiter picks one
// PEB at a time with a round-robin pointer. It then stays locked on that PEB
// for exactly BURST_LEN beats, which are the rows of one tile. The beats pass
// through a single output register stage toward the GB.
//
// Parameters:
//   NUM_PEB     number of PEB requesters
//   PSUM_WIDTH  beat width in bits
//   BURST_LEN   beats per grant
//
// Ports:
//   clk           sole clock; all state changes on its rising edge
//   rst           asynchronous active-high reset
//   PEBPSUM_val   per-PEB beat valid
//   PEBPSUM_data  per-PEB beat; PEB i is at [PSUM_WIDTH*i +: PSUM_WIDTH]
//   PSUMPEB_rdy   per-PEB accept; only the granted PEB can see a 1
//   PSUMGB_val    beat valid toward the GB
//   PSUMGB_data   beat toward the GB
//   PSUMGB_id     index of the PEB that produced PSUMGB_data
//   PSUMGB_last   high on the final beat of a burst
//   GBPSUM_rdy    GB accept
//
// Optional build macro PSUMGB_ARB_STAT_EN:
//   When this macro is defined, the module has two more outputs. Both are
//   32-bit wrapping counters that reset to 0.
//   stat_beat_cnt   beats transferred to the GB
//   stat_stall_cnt  cycles with PSUMGB_val high and GBPSUM_rdy low

module psumgb_arb #(
  parameter int NUM_PEB    = 16,
  parameter int PSUM_WIDTH = 512,
  parameter int BURST_LEN  = 3,
  localparam int ID_W      = (NUM_PEB > 1) ? $clog2(NUM_PEB) : 1,
  localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PEB-1:0]            PEBPSUM_val,
  input  logic [NUM_PEB*PSUM_WIDTH-1:0] PEBPSUM_data,
  output logic [NUM_PEB-1:0]            PSUMPEB_rdy,
  output logic                          PSUMGB_val,
  output logic [PSUM_WIDTH-1:0]         PSUMGB_data,
  output logic [ID_W-1:0]               PSUMGB_id,
  output logic                          PSUMGB_last,
  input  logic                          GBPSUM_rdy
`ifdef PSUMGB_ARB_STAT_EN
  ,
  output logic [31:0]                   stat_beat_cnt,
  output logic [31:0]                   stat_stall_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ID_W-1:0]       gnt;
  logic [ID_W-1:0]       gnt_next;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       ptr_next;
  logic [CNT_W-1:0]      cnt_beat;
  logic [CNT_W-1:0]      cnt_next;

  logic                  out_free;
  logic                  accept;
  logic                  last_beat;
  logic                  sel_found;
  logic [ID_W-1:0]       sel_idx;
  logic [ID_W:0]         scan_idx;
  logic [PSUM_WIDTH-1:0] sel_data;

  // The output stage can take a new beat if it is empty, or if the GB is
  // draining it in this same cycle. This gives one beat per cycle without
  // adding a second buffer slot.
  assign out_free  = !PSUMGB_val || GBPSUM_rdy;
  assign accept    = (state == BURST) && out_free && PEBPSUM_val[gnt];
  assign last_beat = (cnt_beat == CNT_W'(BURST_LEN - 1));
  assign sel_data  = PEBPSUM_data[PSUM_WIDTH*int'(gnt) +: PSUM_WIDTH];

  // Round-robin scan. Candidates start at ptr and wrap modulo NUM_PEB.
  // The first requester found wins. scan_idx has one extra bit, so the
  // wrap is a single conditional subtract and works for any NUM_PEB.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_PEB; k++) begin
      scan_idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_PEB)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_PEB);
      end
      if (!sel_found && PEBPSUM_val[scan_idx[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // Control registers: FSM state, grant, round-robin pointer and beat count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      cnt_beat <= '0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      ptr      <= ptr_next;
      cnt_beat <= cnt_next;
    end
  end

  // IDLE spends one cycle on arbitration only and accepts no beat.
  // BURST stays on gnt until the final beat is accepted. A requester that
  // drops its valid mid-burst keeps the grant; nothing preempts it.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    ptr_next   = ptr;
    cnt_next   = cnt_beat;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_next = BURST;
          gnt_next   = sel_idx;
          cnt_next   = '0;
        end
      end
      BURST: begin
        if (accept) begin
          if (last_beat) begin
            state_next = IDLE;
            cnt_next   = '0;
            ptr_next   = (gnt == ID_W'(NUM_PEB - 1)) ? '0 : gnt + 1'b1;
          end else begin
            cnt_next = cnt_beat + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Only the granted PEB sees ready, and only when the output stage can
  // take its beat. During reset state is IDLE, so this output reads 0.
  always_comb begin
    PSUMPEB_rdy = '0;
    if ((state == BURST) && out_free) begin
      PSUMPEB_rdy[gnt] = 1'b1;
    end
  end

  // Output register stage. An accepted beat loads the stage, whether or not
  // the previous beat leaves in the same cycle. If nothing new arrives, a
  // completed transfer empties the stage. While the GB stalls, all fields
  // hold their values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PSUMGB_val  <= 1'b0;
      PSUMGB_data <= '0;
      PSUMGB_id   <= '0;
      PSUMGB_last <= 1'b0;
    end else if (accept) begin
      PSUMGB_val  <= 1'b1;
      PSUMGB_data <= sel_data;
      PSUMGB_id   <= gnt;
      PSUMGB_last <= last_beat;
    end else if (GBPSUM_rdy) begin
      PSUMGB_val  <= 1'b0;
    end
  end

`ifdef PSUMGB_ARB_STAT_EN
  // Traffic counters. Both wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beat_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else if (PSUMGB_val) begin
      if (GBPSUM_rdy) begin
        stat_beat_cnt  <= stat_beat_cnt + 32'd1;
      end else begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_psumgb_arb.sv
`timescale 1ns/1ps

// Bench for psumgb_arb.
// The reference model works at transaction level. It tracks the current
// owner, the number of beats it has delivered, the round-robin start point,
// and a queue of beats that wait for the GB. From these it predicts every
// output in every cycle.
module tb_psumgb_arb;

  localparam int NUM_PEB    = 16;
  localparam int PSUM_WIDTH = 512;
  localparam int BURST_LEN  = 3;
  localparam int ID_W       = $clog2(NUM_PEB);
  localparam int W          = PSUM_WIDTH;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_PEB-1:0]            PEBPSUM_val;
  logic [NUM_PEB*PSUM_WIDTH-1:0] PEBPSUM_data;
  logic [NUM_PEB-1:0]            PSUMPEB_rdy;
  logic                          PSUMGB_val;
  logic [PSUM_WIDTH-1:0]         PSUMGB_data;
  logic [ID_W-1:0]               PSUMGB_id;
  logic                          PSUMGB_last;
  logic                          GBPSUM_rdy;
`ifdef PSUMGB_ARB_STAT_EN
  logic [31:0]                   stat_beat_cnt;
  logic [31:0]                   stat_stall_cnt;
`endif

  psumgb_arb #(
    .NUM_PEB   (NUM_PEB),
    .PSUM_WIDTH(PSUM_WIDTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PEBPSUM_val (PEBPSUM_val),
    .PEBPSUM_data(PEBPSUM_data),
    .PSUMPEB_rdy (PSUMPEB_rdy),
    .PSUMGB_val  (PSUMGB_val),
    .PSUMGB_data (PSUMGB_data),
    .PSUMGB_id   (PSUMGB_id),
    .PSUMGB_last (PSUMGB_last),
    .GBPSUM_rdy  (GBPSUM_rdy)
`ifdef PSUMGB_ARB_STAT_EN
    ,
    .stat_beat_cnt (stat_beat_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           id;
    logic         last;
  } beat_t;

  int           checks = 0;
  int           errors = 0;
  int           seq[NUM_PEB];
  int           m_owner;
  int           m_done;
  int           m_ptr;
  beat_t        out_q[$];
  logic [31:0]  m_beats;
  logic [31:0]  m_stalls;

  localparam logic [NUM_PEB-1:0] ALL = {NUM_PEB{1'b1}};

  // Each 32-bit lane of a beat encodes its PEB, its lane number and its
  // sequence number. A wrong slice, a wrong source or a lost beat therefore
  // shows up as a data mismatch.
  function automatic logic [W-1:0] beat_data(input int peb, input int s);
    logic [W-1:0] d;
    d = '0;
    for (int j = 0; j < W/32; j++) begin
      d[32*j +: 32] = {8'(peb), 8'(j), 16'(s)};
    end
    return d;
  endfunction

  function automatic int rr_pick(input logic [NUM_PEB-1:0] v, input int from);
    for (int k = 0; k < NUM_PEB; k++) begin
      if (v[(from + k) % NUM_PEB]) return (from + k) % NUM_PEB;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_clear();
    m_owner  = -1;
    m_done   = 0;
    m_ptr    = 0;
    out_q.delete();
    m_beats  = '0;
    m_stalls = '0;
  endtask

  // This task asserts reset in the middle of a low clock phase. All outputs
  // must drop with no clock edge in between. Valid is cleared while reset is
  // high, so the untracked edge right after release sees no requests.
  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_rdy",  W'(PSUMPEB_rdy), '0);
    checkOutput("rst_val",  W'(PSUMGB_val),  '0);
    checkOutput("rst_data", PSUMGB_data,     '0);
    checkOutput("rst_id",   W'(PSUMGB_id),   '0);
    checkOutput("rst_last", W'(PSUMGB_last), '0);
`ifdef PSUMGB_ARB_STAT_EN
    checkOutput("rst_stat_beat",  W'(stat_beat_cnt),  '0);
    checkOutput("rst_stat_stall", W'(stat_stall_cnt), '0);
`endif
    PEBPSUM_val = '0;
    GBPSUM_rdy  = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // This task runs one clock cycle. It drives the inputs, checks every output
  // against the model's prediction, and then advances the model across the
  // rising edge.
  task automatic applyStimulus(input logic [NUM_PEB-1:0] v, input logic g);
    logic [NUM_PEB-1:0] exp_rdy;
    beat_t              b;
    @(negedge clk);
    PEBPSUM_val = v;
    GBPSUM_rdy  = g;
    for (int i = 0; i < NUM_PEB; i++) begin
      PEBPSUM_data[W*i +: W] = beat_data(i, seq[i]);
    end
    #1;
    exp_rdy = '0;
    if (m_owner >= 0 && (out_q.size() == 0 || g)) exp_rdy[m_owner] = 1'b1;
    checkOutput("peb_rdy", W'(PSUMPEB_rdy), W'(exp_rdy));
    checkOutput("gb_val",  W'(PSUMGB_val),  W'(out_q.size() != 0));
    if (out_q.size() != 0) begin
      checkOutput("gb_data", PSUMGB_data,     out_q[0].data);
      checkOutput("gb_id",   W'(PSUMGB_id),   W'(out_q[0].id));
      checkOutput("gb_last", W'(PSUMGB_last), W'(out_q[0].last));
    end
`ifdef PSUMGB_ARB_STAT_EN
    checkOutput("stat_beat",  W'(stat_beat_cnt),  W'(m_beats));
    checkOutput("stat_stall", W'(stat_stall_cnt), W'(m_stalls));
`endif
    if (out_q.size() != 0) begin
      if (g) begin
        b = out_q.pop_front();
        m_beats = m_beats + 32'd1;
      end else begin
        m_stalls = m_stalls + 32'd1;
      end
    end
    if (m_owner >= 0) begin
      if (v[m_owner] && exp_rdy[m_owner]) begin
        b.data = beat_data(m_owner, seq[m_owner]);
        b.id   = m_owner;
        b.last = (m_done == BURST_LEN - 1);
        out_q.push_back(b);
        seq[m_owner]++;
        m_done++;
        if (m_done == BURST_LEN) begin
          m_ptr   = (m_owner + 1) % NUM_PEB;
          m_owner = -1;
        end
      end
    end else begin
      m_owner = rr_pick(v, m_ptr);
      m_done  = 0;
    end
    @(posedge clk);
  endtask

  initial begin
    logic [NUM_PEB-1:0] mask;
    for (int i = 0; i < NUM_PEB; i++) seq[i] = 0;
    rst          = 1'b1;
    PEBPSUM_val  = '0;
    PEBPSUM_data = '0;
    GBPSUM_rdy   = 1'b1;
    model_clear();
    pulseReset();

    // Only PEB5 requests, and the GB is always ready.
    for (int c = 0; c < 12; c++) applyStimulus(16'h0020, 1'b1);

    // Every PEB requests continuously from reset. The grants sweep 0..15
    // and then wrap back to 0.
    pulseReset();
    for (int c = 0; c < 16*(BURST_LEN+1) + 8; c++) applyStimulus(ALL, 1'b1);

    // The GB stalls for 4 cycles in the middle of a burst.
    pulseReset();
    for (int c = 0; c < 3; c++) applyStimulus(ALL, 1'b1);
    for (int c = 0; c < 4; c++) applyStimulus(ALL, 1'b0);
    for (int c = 0; c < 10; c++) applyStimulus(ALL, 1'b1);

    // PEB3 drops its valid after its first beat while PEB4 keeps requesting.
    pulseReset();
    for (int c = 0; c < 2; c++) applyStimulus(16'h0018, 1'b1);
    for (int c = 0; c < 5; c++) applyStimulus(16'h0010, 1'b1);
    for (int c = 0; c < 10; c++) applyStimulus(16'h0018, 1'b1);

    // Reset arrives in the middle of a burst while the output is valid.
    pulseReset();
    for (int c = 0; c < 4; c++) applyStimulus(ALL, 1'b1);
    pulseReset();
    for (int c = 0; c < 6; c++) applyStimulus(16'h0c06, 1'b1);

    // After PEB15 is granted, the pointer wraps, so PEB0 goes before PEB14.
    pulseReset();
    applyStimulus(16'h8000, 1'b1);
    for (int c = 0; c < 14; c++) applyStimulus(16'hc001, 1'b1);

    // Random traffic. The requester subset changes every 100 cycles, the GB
    // stalls about one cycle in four, and a rare reset occurs.
    mask = ALL;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) mask = NUM_PEB'($urandom) | NUM_PEB'(1 << $urandom_range(0, NUM_PEB-1));
      if ($urandom_range(0, 599) == 0) pulseReset();
      applyStimulus(NUM_PEB'($urandom) & mask, ($urandom_range(0, 3) != 0));
    end

    // Drain the output stage with the GB ready.
    for (int c = 0; c < 8; c++) applyStimulus('0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psumgb_arb.md
PSUMGB_ARB -- requirements
Module: psumgb_arb

Interface
REQ-001 SHALL have parameter NUM_PEB, default 16, number of PEB requesters.
REQ-002 SHALL have parameter PSUM_WIDTH, default 512, beat width (16 x 32-bit psums).
REQ-003 SHALL have parameter BURST_LEN, default 3, beats per grant (rows 0/1/2 of one tile).
REQ-004 SHALL have port clk  in  1  sole clock, all state on posedge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port PEBPSUM_val  in  NUM_PEB  per-PEB beat valid.
REQ-007 SHALL have port PEBPSUM_data  in  NUM_PEB*PSUM_WIDTH  per-PEB beat; PEB i at [PSUM_WIDTH*i +: PSUM_WIDTH].
REQ-008 SHALL have port PSUMPEB_rdy  out  NUM_PEB  per-PEB accept.
REQ-009 SHALL have port PSUMGB_val  out  1  beat valid toward GB.
REQ-010 SHALL have port PSUMGB_data  out  PSUM_WIDTH  beat toward GB.
REQ-011 SHALL have port PSUMGB_id  out  clog2(NUM_PEB)  source PEB of PSUMGB_data.
REQ-012 SHALL have port PSUMGB_last  out  1  high on final beat of a burst.
REQ-013 SHALL have port GBPSUM_rdy  in  1  GB accept.

Function
REQ-014 SHALL implement FSM IDLE/BURST; beat counter cnt_beat 0..BURST_LEN-1; grant register gnt; round-robin pointer ptr.
REQ-015 SHALL, in IDLE with any PEBPSUM_val high, select first i with val set scanning ptr, ptr+1, ... modulo NUM_PEB, load gnt=i, cnt_beat=0, enter BURST next cycle (one arbitration cycle, no accept in IDLE).
REQ-016 SHALL stay in IDLE while all PEBPSUM_val are low.
REQ-017 SHALL drive PSUMPEB_rdy[i] = (state==BURST) && (i==gnt) && (!PSUMGB_val || GBPSUM_rdy); all other bits 0.
REQ-018 SHALL, on accept (PEBPSUM_val[gnt] && PSUMPEB_rdy[gnt]), register data, id=gnt, last=(cnt_beat==BURST_LEN-1) into the output stage and set PSUMGB_val next cycle (latency 1).
REQ-019 SHALL hold PSUMGB_val/data/id/last stable while PSUMGB_val && !GBPSUM_rdy; clear PSUMGB_val after transfer unless a new beat is accepted in the same cycle.
REQ-020 SHALL, on accept of beat BURST_LEN-1, return to IDLE and set ptr=(gnt+1) mod NUM_PEB.
REQ-021 SHALL stay locked on gnt in BURST if PEBPSUM_val[gnt] drops mid-burst; no timeout, no preemption.
REQ-022 SHALL sustain one beat/cycle within a burst when GBPSUM_rdy is high; one bubble between bursts.
REQ-023 SHALL never drop or duplicate a beat; beat order per PEB preserved.

Reset
REQ-024 SHALL on rst asynchronously force state=IDLE, gnt=0, ptr=0, cnt_beat=0, PSUMGB_val=0, PSUMGB_data=0, PSUMGB_id=0, PSUMGB_last=0, PSUMPEB_rdy=0.
REQ-025 SHALL discard any held or partial burst on rst; first post-reset arbitration starts at PEB 0.

Configuration
REQ-026 SHALL, with PSUMGB_ARB_STAT_EN defined, add outputs stat_beat_cnt (32, out, beats transferred to GB) and stat_stall_cnt (32, out, cycles PSUMGB_val && !GBPSUM_rdy), both reset to 0 by rst and wrapping at 2^32.
REQ-027 SHALL, without PSUMGB_ARB_STAT_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-028 SHALL cover: only PEB5 valid, GBPSUM_rdy=1 -> IDLE 1 cycle, beats on PSUMGB 1 cycle after each accept, id=5, last on 3rd beat, next ptr=6.
REQ-029 SHALL cover: all 16 PEBs valid continuously after reset -> burst order 0,1,...,15,0, each 3 beats, 1 bubble between bursts.
REQ-030 SHALL cover: GBPSUM_rdy low 4 cycles mid-burst -> output held stable, PSUMPEB_rdy[gnt]=0, no beat lost, stat_stall_cnt +4 when enabled.
REQ-031 SHALL cover: PEB3 drops val after beat 1 for 5 cycles while PEB4 valid -> PEB4 not granted until PEB3 completes beat 3.
REQ-032 SHALL cover: rst asserted mid-burst with PSUMGB_val=1 -> all outputs 0 immediately, next grant to lowest valid index from 0.
REQ-033 SHALL cover: PEB15 granted, then PEB0 and PEB14 valid -> wrap grants PEB0 before PEB14.
